// File: rtl/dpram_pkg.sv
// dpram_pkg: shared definitions for the dpram_pipe dual-port RAM.
//   - write-mode encodings used by WMODE_A / WMODE_B
//   - clear-engine state type
//   - dpram_clog2(): address width needed to cover a given depth
package dpram_pkg;

  localparam int unsigned WM_NO_CHANGE   = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_READ_FIRST  = 2;

  typedef enum logic {
    StClear,
    StIdle
  } clr_state_e;

  // Ceiling log2 of a depth, never less than 1 so a counter always has a bit.
  function automatic int unsigned dpram_clog2(input int unsigned depth);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dpram_port_out.sv
// dpram_port_out: per-port read output stage of dpram_pipe.
//   Stage 1 captures read data (or write data, per write mode) on an accepted
//   access; with OUT_REG != 0 a second register, gated by oce, drives dout.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   acc             access accepted this cycle (ce and not busy)
//   wre             access is a write
//   oce             output-register enable (OUT_REG != 0 only)
//   din             write data of this port
//   rdata           array contents at this port's address before the edge
//   dout, rvalid    read data and its valid tag
module dpram_port_out
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OUT_REG = 1,
  parameter int unsigned WMODE   = WM_NO_CHANGE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              wre,
  input  logic              oce,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);

  logic [DATA_W-1:0] s1_d, s1_q;
  logic              s1v_d, s1v_q;

  // Data holds when nothing new is produced; only the valid tag drops.
  always_comb begin
    s1_d  = s1_q;
    s1v_d = 1'b0;
    if (acc) begin
      if (!wre) begin
        s1_d  = rdata;
        s1v_d = 1'b1;
      end else begin
        case (WMODE)
          WM_WRITE_FIRST: begin
            s1_d  = din;
            s1v_d = 1'b1;
          end
          WM_READ_FIRST: begin
            s1_d  = rdata;
            s1v_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= '0;
      s1v_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s1v_q <= s1v_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] out_q;
    logic              outv_q;

    // Stall-hold only: stage 1 keeps advancing while oce is low.
    always_ff @(posedge clk) begin
      if (reset) begin
        out_q  <= '0;
        outv_q <= 1'b0;
      end else if (oce) begin
        out_q  <= s1_q;
        outv_q <= s1v_q;
      end
    end

    assign dout   = out_q;
    assign rvalid = outv_q;
  end else begin : g_no_out_reg
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = s1_q;
    assign rvalid     = s1v_q;
  end

endmodule

// File: rtl/dpram_pipe.sv
// dpram_pipe: single-clock true dual-port RAM, 2^ADDR_W words of DATA_W bits.
//   Port A wins same-address write collisions (collision pulses one cycle).
//   Cross-port reads of a word written in the same cycle return the old data.
//   Optional build macro DPRAM_CLEAR_EN: after reset a clear engine zeroes the
//   whole array over 2^ADDR_W cycles while busy masks all port accesses.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cea/ceb, wrea/wreb      access enable, write select
//   ocea/oceb               output-register enable (OUT_REG = 1)
//   ada/adb, dina/dinb      address, write data
//   douta/doutb, rvalida/b  read data and valid tag
//   collision               both ports wrote the same address last edge
//   busy                    clear engine running
module dpram_pipe
  import dpram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned OUT_REG = 1,
  parameter int unsigned WMODE_A = WM_NO_CHANGE,
  parameter int unsigned WMODE_B = WM_NO_CHANGE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cea,
  input  logic              ceb,
  input  logic              wrea,
  input  logic              wreb,
  input  logic              ocea,
  input  logic              oceb,
  input  logic [ADDR_W-1:0] ada,
  input  logic [ADDR_W-1:0] adb,
  input  logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] douta,
  output logic [DATA_W-1:0] doutb,
  output logic              rvalida,
  output logic              rvalidb,
  output logic              collision,
  output logic              busy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  logic              acc_a, acc_b, we_a, we_b;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              collision_q;

  assign acc_a = cea & ~busy;
  assign acc_b = ceb & ~busy;
  assign we_a  = acc_a & wrea;
  assign we_b  = acc_b & wreb;

`ifdef DPRAM_CLEAR_EN
  localparam int unsigned CntW = dpram_clog2(Depth);

  clr_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last word is written in the same cycle the FSM leaves StClear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Depth - 1)) state_d = StIdle;
      end
      StIdle:  ;
      default: state_d = StClear;
    endcase
  end

  assign busy     = (state_q == StClear);
  assign clr_we   = busy;
  assign clr_addr = ADDR_W'(cnt_q);
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (we_b) mem[adb] <= dinb;
      if (we_a) mem[ada] <= dina;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) collision_q <= 1'b0;
    else       collision_q <= we_a & we_b & (ada == adb);
  end

  assign collision = collision_q;

  dpram_port_out #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG),
    .WMODE   (WMODE_A)
  ) u_out_a (
    .clk    (clk),
    .reset  (reset),
    .acc    (acc_a),
    .wre    (wrea),
    .oce    (ocea),
    .din    (dina),
    .rdata  (mem[ada]),
    .dout   (douta),
    .rvalid (rvalida)
  );

  dpram_port_out #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG),
    .WMODE   (WMODE_B)
  ) u_out_b (
    .clk    (clk),
    .reset  (reset),
    .acc    (acc_b),
    .wre    (wreb),
    .oce    (oceb),
    .din    (dinb),
    .rdata  (mem[adb]),
    .dout   (doutb),
    .rvalid (rvalidb)
  );

endmodule

// File: tb/tb_dpram_pipe.sv
// tb_dpram_pipe: two dpram_pipe instances checked against a behavioural model.
//   u=0: defaults (ADDR_W=14, OUT_REG=1, both ports NO_CHANGE)
//   u=1: ADDR_W=4, OUT_REG=0, port A READ_FIRST, port B WRITE_FIRST
module tb_dpram_pipe;

`ifdef DPRAM_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cea[2], ceb[2], wrea[2], wreb[2], ocea[2], oceb[2];
  logic [13:0] ada[2], adb[2];
  logic [7:0]  dina[2], dinb[2], douta[2], doutb[2];
  logic        rvalida[2], rvalidb[2], collision[2], busy[2];

  int checks = 0;
  int errors = 0;

  dpram_pipe dut0 (
    .clk       (clk),
    .reset     (reset),
    .cea       (cea[0]),
    .ceb       (ceb[0]),
    .wrea      (wrea[0]),
    .wreb      (wreb[0]),
    .ocea      (ocea[0]),
    .oceb      (oceb[0]),
    .ada       (ada[0]),
    .adb       (adb[0]),
    .dina      (dina[0]),
    .dinb      (dinb[0]),
    .douta     (douta[0]),
    .doutb     (doutb[0]),
    .rvalida   (rvalida[0]),
    .rvalidb   (rvalidb[0]),
    .collision (collision[0]),
    .busy      (busy[0])
  );

  dpram_pipe #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .OUT_REG (0),
    .WMODE_A (2),
    .WMODE_B (1)
  ) dut1 (
    .clk       (clk),
    .reset     (reset),
    .cea       (cea[1]),
    .ceb       (ceb[1]),
    .wrea      (wrea[1]),
    .wreb      (wreb[1]),
    .ocea      (ocea[1]),
    .oceb      (oceb[1]),
    .ada       (ada[1][3:0]),
    .adb       (adb[1][3:0]),
    .dina      (dina[1]),
    .dinb      (dinb[1]),
    .douta     (douta[1]),
    .doutb     (doutb[1]),
    .rvalida   (rvalida[1]),
    .rvalidb   (rvalidb[1]),
    .collision (collision[1]),
    .busy      (busy[1])
  );

  // ---------------- behavioural model ----------------
  int unsigned depth_of[2] = '{16384, 16};
  bit          oreg_of[2]  = '{1'b1, 1'b0};
  int unsigned wm_of[2][2] = '{'{0, 0}, '{2, 1}};

  logic [7:0] mm0[int];
  logic [7:0] mm1[int];

  logic [7:0] s1d[2][2], od[2][2];
  bit         s1k[2][2], s1v[2][2], ok[2][2], ov[2][2];
  bit         ecoll[2];
  int         bcnt[2];
  bit         model_on = 1'b0;

  function automatic void rd_model(input int u, input int a, output logic [7:0] d, output bit k);
    d = 8'h00;
    k = ClrEn;
    if (u == 0 && mm0.exists(a)) begin d = mm0[a]; k = 1'b1; end
    if (u == 1 && mm1.exists(a)) begin d = mm1[a]; k = 1'b1; end
  endfunction

  function automatic void wr_model(input int u, input int a, input logic [7:0] d);
    if (u == 0) mm0[a] = d;
    else        mm1[a] = d;
  endfunction

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      bit         bz;
      bit         acc[2], wr[2], oce[2], oldk[2];
      int         a[2];
      logic [7:0] din[2], old[2];
      if (reset) begin
        for (int p = 0; p < 2; p++) begin
          s1d[u][p] = 8'h00; s1k[u][p] = 1'b1; s1v[u][p] = 1'b0;
          od[u][p]  = 8'h00; ok[u][p]  = 1'b1; ov[u][p]  = 1'b0;
        end
        ecoll[u] = 1'b0;
        bcnt[u]  = ClrEn ? int'(depth_of[u]) : 0;
        if (ClrEn) begin
          if (u == 0) mm0.delete();
          else        mm1.delete();
        end
      end else begin
        bz     = (bcnt[u] != 0);
        acc[0] = cea[u] && !bz;   acc[1] = ceb[u] && !bz;
        wr[0]  = wrea[u];         wr[1]  = wreb[u];
        oce[0] = ocea[u];         oce[1] = oceb[u];
        a[0]   = int'(ada[u]) % int'(depth_of[u]);
        a[1]   = int'(adb[u]) % int'(depth_of[u]);
        din[0] = dina[u];         din[1] = dinb[u];
        for (int p = 0; p < 2; p++) rd_model(u, a[p], old[p], oldk[p]);
        for (int p = 0; p < 2; p++) begin
          if (oreg_of[u] && oce[p]) begin
            od[u][p] = s1d[u][p]; ok[u][p] = s1k[u][p]; ov[u][p] = s1v[u][p];
          end
          if (acc[p] && (!wr[p] || wm_of[u][p] == 2)) begin
            s1d[u][p] = old[p]; s1k[u][p] = oldk[p]; s1v[u][p] = 1'b1;
          end else if (acc[p] && wm_of[u][p] == 1) begin
            s1d[u][p] = din[p]; s1k[u][p] = 1'b1; s1v[u][p] = 1'b1;
          end else begin
            s1v[u][p] = 1'b0;
          end
          if (!oreg_of[u]) begin
            od[u][p] = s1d[u][p]; ok[u][p] = s1k[u][p]; ov[u][p] = s1v[u][p];
          end
        end
        ecoll[u] = acc[0] && wr[0] && acc[1] && wr[1] && (a[0] == a[1]);
        if (acc[1] && wr[1]) wr_model(u, a[1], din[1]);
        if (acc[0] && wr[0]) wr_model(u, a[0], din[0]);
        if (bcnt[u] > 0) bcnt[u]--;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int u = 0; u < 2; u++) begin
      if (ok[u][0]) chk($sformatf("u%0d_douta", u), 32'(douta[u]), 32'(od[u][0]));
      if (ok[u][1]) chk($sformatf("u%0d_doutb", u), 32'(doutb[u]), 32'(od[u][1]));
      chk($sformatf("u%0d_rvalida", u), 32'(rvalida[u]), 32'(ov[u][0]));
      chk($sformatf("u%0d_rvalidb", u), 32'(rvalidb[u]), 32'(ov[u][1]));
      chk($sformatf("u%0d_collision", u), 32'(collision[u]), 32'(ecoll[u]));
      chk($sformatf("u%0d_busy", u), 32'(busy[u]), 32'(bcnt[u] != 0));
    end
  endtask

  always begin
    @(posedge clk);
    model_edge();
    if (reset) model_on = 1'b1;
    #1;
    if (model_on) compare();
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int u = 0; u < 2; u++) begin
      cea[u] = 1'b0; ceb[u] = 1'b0; wrea[u] = 1'b0; wreb[u] = 1'b0;
      ocea[u] = 1'b1; oceb[u] = 1'b1;
      ada[u] = '0; adb[u] = '0; dina[u] = '0; dinb[u] = '0;
    end
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy[0] && n < 20000) begin
      step();
      n++;
    end
    chk(name, 32'(n), ClrEn ? 32'd16384 : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] stall_exp [8];
    stall_exp = '{8'h40, 8'h41, 8'h41, 8'h41, 8'h41, 8'h45, 8'h46, 8'h47};

    reset = 1'b1;
    idle_all();
    step(); step();
    chk("rst_douta", 32'(douta[0]), 32'h0);
    chk("rst_rvalida", 32'(rvalida[0]), 32'h0);
    chk("rst_collision", 32'(collision[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'(ClrEn));
    reset = 1'b0;
    count_busy("clear_cycles");

    // Reads of both ends of the array; output appears two edges after access.
    cea[0] = 1'b1; ada[0] = 14'h0000;
    step();
    chk("rd_lat1_rvalida", 32'(rvalida[0]), 32'h0);
    ada[0] = 14'h3FFF;
    step();
    chk("rd0_rvalida", 32'(rvalida[0]), 32'h1);
`ifdef DPRAM_CLEAR_EN
    chk("rd0_douta", 32'(douta[0]), 32'h0);
`endif
    cea[0] = 1'b0;
    step();
    chk("rd3fff_rvalida", 32'(rvalida[0]), 32'h1);
`ifdef DPRAM_CLEAR_EN
    chk("rd3fff_douta", 32'(douta[0]), 32'h0);
`endif
    step();
    chk("rd_idle_rvalida", 32'(rvalida[0]), 32'h0);

    // Write on A, read back on B.
    cea[0] = 1'b1; wrea[0] = 1'b1; ada[0] = 14'h1234; dina[0] = 8'hA5;
    step();
    idle_all();
    ceb[0] = 1'b1; adb[0] = 14'h1234;
    step();
    idle_all();
    step();
    chk("xrd_doutb", 32'(doutb[0]), 32'hA5);
    chk("xrd_rvalidb", 32'(rvalidb[0]), 32'h1);
    chk("nc_wr_rvalida", 32'(rvalida[0]), 32'h0);

    // Same-address write collision: A wins.
    cea[0] = 1'b1; wrea[0] = 1'b1; ada[0] = 14'h0100; dina[0] = 8'h11;
    ceb[0] = 1'b1; wreb[0] = 1'b1; adb[0] = 14'h0100; dinb[0] = 8'h22;
    step();
    chk("coll_pulse", 32'(collision[0]), 32'h1);
    idle_all();
    step();
    chk("coll_clear", 32'(collision[0]), 32'h0);
    cea[0] = 1'b1; ada[0] = 14'h0100;
    step();
    idle_all();
    step();
    chk("coll_winner", 32'(douta[0]), 32'h11);

    // Read stream on B with a three-cycle oceb stall.
    for (int i = 0; i < 8; i++) begin
      cea[0] = 1'b1; wrea[0] = 1'b1; ada[0] = 14'(i); dina[0] = 8'(8'h40 + i);
      step();
    end
    idle_all();
    for (int t = 0; t < 10; t++) begin
      ceb[0]  = (t < 8);
      adb[0]  = 14'(t);
      oceb[0] = !(t >= 3 && t <= 5);
      step();
      if (t >= 1 && t <= 8) begin
        chk($sformatf("stall_doutb_%0d", t), 32'(doutb[0]), 32'(stall_exp[t-1]));
        chk($sformatf("stall_rvalidb_%0d", t), 32'(rvalidb[0]), 32'h1);
      end
    end
    chk("stall_end_rvalidb", 32'(rvalidb[0]), 32'h0);
    chk("stall_end_doutb", 32'(doutb[0]), 32'h47);
    idle_all();

    // READ_FIRST on port A and WRITE_FIRST on port B of the second instance.
    cea[1] = 1'b1; wrea[1] = 1'b1; ada[1] = 14'h5; dina[1] = 8'h3C;
    step();
    dina[1] = 8'hC3;
    step();
    chk("rf_douta", 32'(douta[1]), 32'h3C);
    chk("rf_rvalida", 32'(rvalida[1]), 32'h1);
    wrea[1] = 1'b0;
    step();
    chk("rf_readback", 32'(douta[1]), 32'hC3);
    idle_all();
    ceb[1] = 1'b1; wreb[1] = 1'b1; adb[1] = 14'h6; dinb[1] = 8'h5A;
    step();
    chk("wf_doutb", 32'(doutb[1]), 32'h5A);
    chk("wf_rvalidb", 32'(rvalidb[1]), 32'h1);
    idle_all();
    step();
    chk("wf_idle_rvalidb", 32'(rvalidb[1]), 32'h0);
    chk("wf_hold_doutb", 32'(doutb[1]), 32'h5A);

    // Randomised traffic, checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      for (int u = 0; u < 2; u++) begin
        cea[u]  = ($urandom_range(0, 9) < 6);
        ceb[u]  = ($urandom_range(0, 9) < 6);
        wrea[u] = $urandom_range(0, 1) != 0;
        wreb[u] = $urandom_range(0, 1) != 0;
        ocea[u] = ($urandom_range(0, 9) < 8);
        oceb[u] = ($urandom_range(0, 9) < 8);
        dina[u] = 8'($urandom);
        dinb[u] = 8'($urandom);
      end
      ada[0] = ($urandom_range(0, 1) != 0 ? 14'h3FF0 : 14'h0000) | 14'($urandom_range(0, 15));
      adb[0] = ($urandom_range(0, 1) != 0 ? 14'h3FF0 : 14'h0000) | 14'($urandom_range(0, 15));
      ada[1] = 14'($urandom_range(0, 15));
      adb[1] = 14'($urandom_range(0, 15));
      step();
    end
    idle_all();

    // Reset with reads in flight flushes the output pipeline.
    cea[0] = 1'b1; ada[0] = 14'h0100;
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst_douta", 32'(douta[0]), 32'h0);
    chk("midrst_rvalida", 32'(rvalida[0]), 32'h0);
    chk("midrst_collision", 32'(collision[0]), 32'h0);
    idle_all();
    reset = 1'b0;
`ifdef DPRAM_CLEAR_EN
    repeat (2048) step();
    chk("midclear_busy", 32'(busy[0]), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
`endif
    count_busy("clear_restart");
    cea[0] = 1'b1; ada[0] = 14'h0100;
    step();
    idle_all();
    step();
    chk("post_rst_contents", 32'(douta[0]), ClrEn ? 32'h00 : 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
